// File: rtl/escritor_quadro_ampliado_pkg.sv
// pacote_video: shared constants, FSM encoding and address-width helper for the frame writer
package pacote_video;
  localparam int LARGURA_PADRAO = 1280;
  localparam int ALTURA_PADRAO = 960;
  typedef enum logic {ESCREVENDO = 1'b0, FIM_QUADRO = 1'b1} estado_t;
  function automatic int calc_end_w(input int largura, input int altura, input int bancos);
    return $clog2(largura * altura * bancos);
  endfunction
endpackage

// File: rtl/escritor_quadro_ampliado_contador.sv
// contador_posicao_quadro: x/y position and multiplier-free line base address
module contador_posicao_quadro
  import pacote_video::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int ALTURA = ALTURA_PADRAO,
  parameter int END_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             incrementa_x,
  input  logic             fim_linha,
  input  logic             reinicia,
  output logic [10:0]      x,
  output logic [9:0]       y,
  output logic [END_W-1:0] base,
  output logic             ultima_linha
);
  logic [10:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [END_W-1:0] base_q, base_d;
  logic volta;
  assign ultima_linha = y_q == 10'(ALTURA - 1);
  assign volta = reinicia || (fim_linha && ultima_linha);
  always_comb begin
    x_d = (reinicia || fim_linha) ? '0 : incrementa_x ? x_q + 11'd1 : x_q;
    y_d = volta ? '0 : fim_linha ? y_q + 10'd1 : y_q;
    base_d = volta ? '0 : fim_linha ? base_q + END_W'(LARGURA) : base_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      base_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      base_q <= base_d;
    end
  end
  assign x = x_q;
  assign y = y_q;
  assign base = base_q;
endmodule

// File: rtl/escritor_quadro_ampliado.sv
// escritor_quadro_ampliado: writes the replicated pixel stream into a frame buffer RAM
// ESCRITOR_DUPLO_BUFFER_EN adds a bank bit to the address and the o_banco_leitura output.
module escritor_quadro_ampliado
  import pacote_video::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int ALTURA = ALTURA_PADRAO,
  parameter int END_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_pixel,
  input  logic             i_pixel_valido,
  input  logic             i_linha_valida,
  input  logic             i_inicio_quadro,
  output logic [END_W-1:0] o_mem_endereco,
  output logic [7:0]       o_mem_dado,
  output logic             o_mem_escrita,
  output logic             o_quadro_pronto,
  output logic             o_erro_linha,
  output logic [10:0]      o_x,
  output logic [9:0]       o_y
`ifdef ESCRITOR_DUPLO_BUFFER_EN
  , output logic           o_banco_leitura
`endif
);
  estado_t estado_q, estado_d;
  logic [10:0] x, x_apos;
  logic [9:0] y;
  logic [END_W-1:0] base, deslocamento, endereco_q, endereco_d;
  logic [7:0] dado_q, dado_d;
  logic ultima, escreve, fim_linha, descarta;
  logic escrita_q, pronto_q, pronto_d, erro_q, erro_d;
  contador_posicao_quadro #(.LARGURA(LARGURA), .ALTURA(ALTURA), .END_W(END_W)) u_contador (
    .clk(clk),
    .rst(rst),
    .incrementa_x(escreve),
    .fim_linha(fim_linha),
    .reinicia(i_inicio_quadro),
    .x(x),
    .y(y),
    .base(base),
    .ultima_linha(ultima)
  );
`ifdef ESCRITOR_DUPLO_BUFFER_EN
  localparam logic [END_W-1:0] QUADRO = END_W'(LARGURA * ALTURA);
  logic banco_q, leitura_q;
  assign deslocamento = banco_q ? QUADRO : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      banco_q <= 1'b0;
      leitura_q <= 1'b0;
    end else if (pronto_d) begin
      banco_q <= ~banco_q;
      leitura_q <= banco_q;
    end
  end
  assign o_banco_leitura = leitura_q;
`else
  assign deslocamento = '0;
`endif
  // A pixel arriving with the line pulse is counted before the width check.
  always_comb begin
    escreve = !i_inicio_quadro && estado_q == ESCREVENDO && i_pixel_valido && x < 11'(LARGURA);
    x_apos = x + {10'd0, escreve};
    fim_linha = !i_inicio_quadro && estado_q == ESCREVENDO && i_linha_valida;
    descarta = !i_inicio_quadro && i_pixel_valido && !escreve;
    erro_d = erro_q || descarta || (fim_linha && x_apos != 11'(LARGURA));
    pronto_d = fim_linha && ultima;
    estado_d = pronto_d ? FIM_QUADRO : ESCREVENDO;
    endereco_d = escreve ? deslocamento + base + END_W'(x) : endereco_q;
    dado_d = escreve ? i_pixel : dado_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= ESCREVENDO;
      endereco_q <= '0;
      dado_q <= '0;
      escrita_q <= 1'b0;
      pronto_q <= 1'b0;
      erro_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      endereco_q <= endereco_d;
      dado_q <= dado_d;
      escrita_q <= escreve;
      pronto_q <= pronto_d;
      erro_q <= erro_d;
    end
  end
  assign o_mem_endereco = endereco_q;
  assign o_mem_dado = dado_q;
  assign o_mem_escrita = escrita_q;
  assign o_quadro_pronto = pronto_q;
  assign o_erro_linha = erro_q;
  assign o_x = x;
  assign o_y = y;
endmodule

// File: tb/tb_escritor_quadro_ampliado.sv
// tb_escritor_quadro_ampliado: scoreboard bench for the frame writer on a 4x2 frame
module tb_escritor_quadro_ampliado;
  import pacote_video::*;
  localparam int L = 4;
  localparam int A = 2;
`ifdef ESCRITOR_DUPLO_BUFFER_EN
  localparam int B = 2;
`else
  localparam int B = 1;
`endif
  localparam int EW = calc_end_w(L, A, B);
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] pix = '0;
  logic pv = 1'b0, lv = 1'b0, ini = 1'b0;
  logic [EW-1:0] o_mem_endereco;
  logic [7:0] o_mem_dado;
  logic o_mem_escrita, o_quadro_pronto, o_erro_linha;
  logic [10:0] o_x;
  logic [9:0] o_y;
`ifdef ESCRITOR_DUPLO_BUFFER_EN
  logic o_banco_leitura;
`endif
  escritor_quadro_ampliado #(.LARGURA(L), .ALTURA(A), .END_W(EW)) dut (
    .clk(clk),
    .rst(rst),
    .i_pixel(pix),
    .i_pixel_valido(pv),
    .i_linha_valida(lv),
    .i_inicio_quadro(ini),
    .o_mem_endereco(o_mem_endereco),
    .o_mem_dado(o_mem_dado),
    .o_mem_escrita(o_mem_escrita),
    .o_quadro_pronto(o_quadro_pronto),
    .o_erro_linha(o_erro_linha),
    .o_x(o_x),
    .o_y(o_y)
`ifdef ESCRITOR_DUPLO_BUFFER_EN
    , .o_banco_leitura(o_banco_leitura)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {int a; int d;} esc_t;
  esc_t fila[$];
  int checks = 0, erros = 0;
  int mx = 0, my = 0, mbank = 0, mread = 0;
  bit merr = 0, mfim = 0, mpronto = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      erros++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic verificar();
    esc_t e;
    chk("escrita", 32'(o_mem_escrita), 32'(fila.size() > 0));
    if (o_mem_escrita && fila.size() > 0) begin
      e = fila.pop_front();
      chk("endereco", 32'(o_mem_endereco), e.a);
      chk("dado", 32'(o_mem_dado), e.d);
    end else if (fila.size() > 0) fila.delete(0);
    chk("pronto", 32'(o_quadro_pronto), 32'(mpronto));
    chk("erro", 32'(o_erro_linha), 32'(merr));
    chk("x", 32'(o_x), mx);
    chk("y", 32'(o_y), my);
`ifdef ESCRITOR_DUPLO_BUFFER_EN
    chk("banco", 32'(o_banco_leitura), mread);
`endif
  endtask
  task automatic ciclo(input bit v, input int p, input bit l, input bit s = 1'b0);
    esc_t e;
    pix = 8'(p); pv = v; lv = l; ini = s; mpronto = 0;
    if (s) begin
      mx = 0; my = 0; mfim = 0;
    end else if (mfim) begin
      if (v) merr = 1;
      mfim = 0;
    end else begin
      if (v && mx < L) begin
        e.a = (B == 2 ? mbank * L * A : 0) + my * L + mx;
        e.d = p & 8'hff;
        fila.push_back(e);
        mx++;
      end else if (v) merr = 1;
      if (l) begin
        if (mx != L) merr = 1;
        mx = 0;
        if (my == A - 1) begin
          my = 0; mpronto = 1; mfim = 1; mread = mbank; mbank ^= 1;
        end else my++;
      end
    end
    @(posedge clk); #1;
    pv = 0; lv = 0; ini = 0;
    verificar();
  endtask
  task automatic reiniciar();
    rst = 1; pv = 0; lv = 0; ini = 0;
    @(posedge clk); #1;
    chk("rst_escrita", 32'(o_mem_escrita), 0);
    chk("rst_endereco", 32'(o_mem_endereco), 0);
    chk("rst_dado", 32'(o_mem_dado), 0);
    chk("rst_pronto", 32'(o_quadro_pronto), 0);
    chk("rst_erro", 32'(o_erro_linha), 0);
    chk("rst_x", 32'(o_x), 0);
    chk("rst_y", 32'(o_y), 0);
`ifdef ESCRITOR_DUPLO_BUFFER_EN
    chk("rst_banco", 32'(o_banco_leitura), 0);
`endif
    rst = 0;
    mx = 0; my = 0; mbank = 0; mread = 0; merr = 0; mfim = 0; mpronto = 0;
    fila.delete();
  endtask
  task automatic linha(input int b, input int n);
    for (int i = 0; i < n; i++) ciclo(1, b + i, 0);
    ciclo(0, 0, 1);
    ciclo(0, 0, 0);
  endtask
  initial begin
    @(posedge clk); #1;
    reiniciar();
    linha(8'h10, 4);
    linha(8'h20, 4);
    linha(8'h30, 3);
    linha(8'h40, 4);
    reiniciar();
    linha(8'h50, 5);
    linha(8'h60, 4);
    reiniciar();
    for (int i = 0; i < 3; i++) ciclo(1, 8'h70 + i, 0);
    ciclo(1, 8'h73, 1);
    linha(8'h80, 4);
    linha(8'h90, 4);
    for (int i = 0; i < 2; i++) ciclo(1, 8'h98 + i, 0);
    reiniciar();
    linha(8'ha0, 4);
    linha(8'hb0, 4);
    ciclo(1, 8'hc0, 0);
    ciclo(1, 8'hc1, 0);
    ciclo(0, 0, 0, 1);
    linha(8'hd0, 4);
    for (int i = 0; i < 4; i++) ciclo(1, 8'he0 + i, 0);
    ciclo(0, 0, 1);
    ciclo(1, 8'hff, 0);
    ciclo(0, 0, 0);
    reiniciar();
    for (int f = 0; f < 2; f++) begin
      linha(8'h11 + 16 * f, 4);
      linha(8'h15 + 16 * f, 4);
    end
    ciclo(0, 0, 0);
    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end
endmodule
